// File: rtl/bnn_label_scoreboard.sv
// Label FIFO + scoreboard pairing BNN input labels with BNN results in order.
// Optional per-class correct counters when SCORE_PERCLASS_EN is defined.
module bnn_label_scoreboard #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_total,
  input  logic             i_in_valid,
  input  logic [3:0]       i_label,
  input  logic             i_res_valid,
  input  logic [3:0]       i_result,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_correct,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last_valid,
  output logic             o_last_match,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic [3:0]       i_class_sel,
  output logic [CNT_W-1:0] o_class_correct
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    occ_q;
  logic [CNT_W-1:0] total_q, pushed_q, count_q, correct_q;
  logic             last_valid_q, last_match_q, overflow_q, underflow_q;

  logic             in_run, fifo_empty, fifo_full;
  logic             push_req, pop_req, bypass, overflow_ev, underflow_ev;
  logic             wr_en, rd_en, score, match, run_end;
  logic [3:0]       pop_label;
  logic [CNT_W-1:0] count_inc, correct_inc;

  always_comb begin
    in_run       = (state_q == S_RUN);
    fifo_empty   = (occ_q == '0);
    fifo_full    = (occ_q == OCC_FULL);
    push_req     = in_run && i_in_valid && (pushed_q < total_q);
    pop_req      = in_run && i_res_valid;
    // Empty FIFO with a same-cycle push: score against the incoming label directly.
    bypass       = push_req && pop_req && fifo_empty;
    overflow_ev  = push_req && !pop_req && fifo_full;
    underflow_ev = pop_req && !push_req && fifo_empty;
    wr_en        = push_req && !bypass && !overflow_ev;
    rd_en        = pop_req && !fifo_empty;
    score        = pop_req && !underflow_ev;
    pop_label    = bypass ? i_label : mem[rd_ptr_q];
    match        = score && (pop_label == i_result);
    count_inc    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    correct_inc  = (correct_q == '1) ? correct_q : correct_q + CNT_W'(1);
    run_end      = score && (count_inc == total_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = (i_total == '0) ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (run_end) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_busy = (state_q == S_RUN);
    o_done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_label;
  end

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      total_q      <= rst ? '0 : i_total;
      pushed_q     <= '0;
      count_q      <= '0;
      correct_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      last_valid_q <= 1'b0;
      last_match_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      last_valid_q <= score;
      if (score) begin
        last_match_q <= match;
        count_q      <= count_inc;
        if (match) correct_q <= correct_inc;
      end
      if (push_req) pushed_q <= pushed_q + CNT_W'(1);
      if (wr_en)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en)    rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_q + OW'(wr_en) - OW'(rd_en);
      if (overflow_ev)  overflow_q  <= 1'b1;
      if (underflow_ev) underflow_q <= 1'b1;
    end
  end

  assign o_count      = count_q;
  assign o_correct    = correct_q;
  assign o_last_valid = last_valid_q;
  assign o_last_match = last_match_q;
  assign o_overflow   = overflow_q;
  assign o_underflow  = underflow_q;

`ifdef SCORE_PERCLASS_EN
  logic [CNT_W-1:0] class_cnt_q [10];

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      for (int unsigned i = 0; i < 10; i++) class_cnt_q[i] <= '0;
    end else if (match) begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (pop_label == 4'(i) && class_cnt_q[i] != '1)
          class_cnt_q[i] <= class_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_class_correct = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i_class_sel == 4'(i)) o_class_correct = class_cnt_q[i];
    end
  end
`else
  logic unused_class_sel;
  assign unused_class_sel = ^i_class_sel;
  assign o_class_correct  = '0;
`endif

endmodule

// File: tb/tb_bnn_label_scoreboard.sv
// Self-checking bench for bnn_label_scoreboard: directed scenarios plus
// randomized runs against a queue-based reference model.
module tb_bnn_label_scoreboard;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst, i_start, i_in_valid, i_res_valid;
  logic [CNT_W-1:0] i_total;
  logic [3:0]       i_label, i_result, i_class_sel;
  logic             o_busy, o_done, o_last_valid, o_last_match, o_overflow, o_underflow;
  logic [CNT_W-1:0] o_correct, o_count, o_class_correct;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // reference model state
  bit       m_busy, m_done, m_last_v, m_last_m, m_ovf, m_udf;
  int       m_count, m_correct, m_total, m_pushed;
  int       m_cls [10];
  bit [3:0] q [$];

  bnn_label_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_total(i_total),
    .i_in_valid(i_in_valid), .i_label(i_label), .i_res_valid(i_res_valid),
    .i_result(i_result), .o_busy(o_busy), .o_done(o_done),
    .o_correct(o_correct), .o_count(o_count), .o_last_valid(o_last_valid),
    .o_last_match(o_last_match), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .i_class_sel(i_class_sel),
    .o_class_correct(o_class_correct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_clear();
    m_busy = 0; m_done = 0; m_last_v = 0; m_last_m = 0; m_ovf = 0; m_udf = 0;
    m_count = 0; m_correct = 0; m_total = 0; m_pushed = 0;
    for (int i = 0; i < 10; i++) m_cls[i] = 0;
    q.delete();
  endfunction

  function automatic logic [37:0] exp_vec();
    return {m_busy, m_done, 16'(m_count), 16'(m_correct), m_last_v, m_last_m, m_ovf, m_udf};
  endfunction

  function automatic logic [37:0] act_vec();
    return {o_busy, o_done, o_count, o_correct, o_last_valid, o_last_match, o_overflow, o_underflow};
  endfunction

  // Drive one cycle of inputs, advance the model, return at the next falling edge.
  task automatic step(input bit st, input int tot, input bit inv, input bit [3:0] lbl,
                      input bit rv, input bit [3:0] res);
    bit push, sc;
    bit [3:0] pl;
    i_start = st; i_total = 16'(tot); i_in_valid = inv; i_label = lbl;
    i_res_valid = rv; i_result = res;
    if (st) begin
      model_clear();
      m_total = tot;
      if (tot == 0) m_done = 1; else m_busy = 1;
    end else begin
      m_last_v = 0;
      if (m_busy) begin
        push = inv && (m_pushed < m_total);
        sc = 0;
        pl = 4'd0;
        if (push) m_pushed++;
        if (rv) begin
          if (q.size() > 0) begin
            pl = q.pop_front(); sc = 1;
            if (push) q.push_back(lbl);
          end else if (push) begin
            pl = lbl; sc = 1;
          end else m_udf = 1;
        end else if (push) begin
          if (q.size() == DEPTH) m_ovf = 1; else q.push_back(lbl);
        end
        if (sc) begin
          m_last_v = 1;
          m_last_m = (pl == res);
          if (m_count < CMAX) m_count++;
          if (pl == res) begin
            if (m_correct < CMAX) m_correct++;
            if (pl < 10 && m_cls[pl] < CMAX) m_cls[pl]++;
          end
          if (m_count == m_total) begin m_busy = 0; m_done = 1; end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 4'd0, 0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_start = 0; i_in_valid = 0; i_res_valid = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (act_vec() !== 38'd0) begin
      bad_cnt++; $display("FAIL reset_outputs got=%h want=0", act_vec());
    end
    total_cnt++;
    if (o_class_correct !== '0) begin
      bad_cnt++; $display("FAIL reset_class got=%0d want=0", o_class_correct);
    end
  endtask

  task automatic test_basic();
    step(1, 3, 0, 0, 0, 0);
    total_cnt++;
    if (o_busy !== 1'b1) begin bad_cnt++; $display("FAIL start_busy got=%b want=1", o_busy); end
    step(0, 0, 1, 4'd7, 0, 0);
    step(0, 0, 1, 4'd2, 0, 0);
    step(0, 0, 1, 4'd1, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 4'd7);
    total_cnt++;
    if (o_last_valid !== 1'b1 || o_last_match !== 1'b1 || o_count !== 16'd1) begin
      bad_cnt++; $display("FAIL basic_first got=%b%b/%0d want=11/1", o_last_valid, o_last_match, o_count);
    end
    step(0, 0, 0, 0, 1, 4'd2);
    step(0, 0, 0, 0, 1, 4'd0);
    total_cnt++;
    if ({o_count, o_correct} !== {16'd3, 16'd2}) begin
      bad_cnt++; $display("FAIL basic_counts got=%0d/%0d want=3/2", o_count, o_correct);
    end
    total_cnt++;
    if ({o_done, o_busy, o_last_match, o_overflow, o_underflow} !== 5'b10000) begin
      bad_cnt++; $display("FAIL basic_flags got=%b want=10000",
                          {o_done, o_busy, o_last_match, o_overflow, o_underflow});
    end
    idle();
    total_cnt++;
    if (o_done !== 1'b1 || o_last_valid !== 1'b0) begin
      bad_cnt++; $display("FAIL basic_done_hold got=%b%b want=10", o_done, o_last_valid);
    end
  endtask

  task automatic test_zero_total();
    step(1, 0, 0, 0, 0, 0);
    total_cnt++;
    if ({o_done, o_busy} !== 2'b10) begin
      bad_cnt++; $display("FAIL zero_done got=%b want=10", {o_done, o_busy});
    end
    step(0, 0, 1, 4'd3, 1, 4'd3);
    step(0, 0, 1, 4'd4, 1, 4'd4);
    total_cnt++;
    if ({o_count, o_correct} !== 32'd0 || o_last_valid !== 1'b0) begin
      bad_cnt++; $display("FAIL zero_ignored got=%0d/%0d/%b want=0/0/0", o_count, o_correct, o_last_valid);
    end
  endtask

  task automatic test_overflow();
    step(1, 20, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i + 1), 0, 0);
    total_cnt++;
    if (o_overflow !== 1'b1) begin bad_cnt++; $display("FAIL ovf_set got=%b want=1", o_overflow); end
    step(1, 20, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'(i + 6), 0, 0);
    step(0, 0, 1, 4'd12, 1, 4'd6);
    total_cnt++;
    if ({o_overflow, o_count, o_correct} !== {1'b0, 16'd1, 16'd1}) begin
      bad_cnt++; $display("FAIL ovf_full_pushpop got=%b/%0d/%0d want=0/1/1", o_overflow, o_count, o_correct);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 4'(i + 7));
    total_cnt++;
    if (act_vec() !== exp_vec() || o_correct !== 16'd4) begin
      bad_cnt++; $display("FAIL ovf_drain got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    step(1, 10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd3);
    total_cnt++;
    if ({o_underflow, o_count, o_last_valid} !== {1'b1, 16'd0, 1'b0}) begin
      bad_cnt++; $display("FAIL udf_set got=%b/%0d/%b want=1/0/0", o_underflow, o_count, o_last_valid);
    end
    step(0, 0, 1, 4'd5, 1, 4'd5);
    total_cnt++;
    if ({o_count, o_correct, o_last_match} !== {16'd1, 16'd1, 1'b1}) begin
      bad_cnt++; $display("FAIL bypass got=%0d/%0d/%b want=1/1/1", o_count, o_correct, o_last_match);
    end
    step(0, 0, 0, 0, 1, 4'd5);
    total_cnt++;
    if (o_count !== 16'd1 || o_underflow !== 1'b1) begin
      bad_cnt++; $display("FAIL bypass_no_residue got=%0d/%b want=1/1", o_count, o_underflow);
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'(i), 0, 0);
    step(0, 0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 1, 4'd9);
    total_cnt++;
    if (o_count !== 16'd2) begin bad_cnt++; $display("FAIL midrun_pre got=%0d want=2", o_count); end
    do_reset();
    total_cnt++;
    if (act_vec() !== 38'd0) begin
      bad_cnt++; $display("FAIL midrun_rst got=%h want=0", act_vec());
    end
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 4'd11, 0, 0);
    step(0, 0, 1, 4'd8, 1, 4'd11);
    step(0, 0, 0, 0, 1, 4'd8);
    total_cnt++;
    if ({o_done, o_count, o_correct} !== {1'b1, 16'd2, 16'd2}) begin
      bad_cnt++; $display("FAIL midrun_fresh got=%b/%0d/%0d want=1/2/2", o_done, o_count, o_correct);
    end
  endtask

  task automatic test_perclass();
    int want3;
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 4'd3, 0, 0);
    step(0, 0, 1, 4'd3, 1, 4'd3);
    step(0, 0, 1, 4'd4, 1, 4'd3);
    step(0, 0, 0, 0, 1, 4'd9);
`ifdef SCORE_PERCLASS_EN
    want3 = 2;
`else
    want3 = 0;
`endif
    i_class_sel = 4'd3; #1;
    total_cnt++;
    if (o_class_correct !== 16'(want3)) begin
      bad_cnt++; $display("FAIL class3 got=%0d want=%0d", o_class_correct, want3);
    end
    i_class_sel = 4'd4; #1;
    total_cnt++;
    if (o_class_correct !== 16'd0) begin bad_cnt++; $display("FAIL class4 got=%0d want=0", o_class_correct); end
    i_class_sel = 4'd12; #1;
    total_cnt++;
    if (o_class_correct !== 16'd0) begin bad_cnt++; $display("FAIL class12 got=%0d want=0", o_class_correct); end
    total_cnt++;
    if ({o_count, o_correct, o_done} !== {16'd3, 16'd2, 1'b1}) begin
      bad_cnt++; $display("FAIL class_counts got=%0d/%0d/%b want=3/2/1", o_count, o_correct, o_done);
    end
  endtask

  task automatic test_random();
    bit inv, rv;
    bit [3:0] lbl, res;
    int cyc;
    for (int run = 0; run < 8; run++) begin
      step(1, $urandom_range(1, 12), 0, 0, 0, 0);
      cyc = 0;
      while (!m_done && cyc < 300) begin
        rv  = ($urandom_range(0, 2) == 0);
        inv = $urandom_range(0, 1) && (q.size() < DEPTH || rv);
        lbl = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) && q.size() > 0) res = q[0];
        else if ($urandom_range(0, 1) && q.size() == 0 && inv) res = lbl;
        else res = 4'($urandom_range(0, 15));
        step(0, 0, inv, lbl, rv, res);
        cyc++;
        total_cnt++;
        if (act_vec() !== exp_vec()) begin
          bad_cnt++; $display("FAIL random_r%0d_c%0d got=%h want=%h", run, cyc, act_vec(), exp_vec());
        end
      end
      total_cnt++;
      if (!m_done) begin bad_cnt++; $display("FAIL random_timeout run=%0d got=notdone want=done", run); end
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_total = '0; i_in_valid = 0; i_label = '0;
    i_res_valid = 0; i_result = '0; i_class_sel = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_total();
    test_overflow();
    test_underflow();
    test_reset_midrun();
    test_perclass();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
